// File: rtl/cdc_afifo_wr_arb.sv
// Round-robin write-port arbiter for cdc_afifo: burst-locked grants capped at maxburst,
// beats tagged {id, last, data}. Optional idle-grant timeout under CDC_AFIFO_ARB_TMO_EN.
module cdc_afifo_wr_arb #(
  parameter int reqcnt   = 4,
  parameter int dbits    = 32,
  parameter int maxburst = 16,
  parameter int tmo      = 64
)(
  input  logic                     i_clk,
  input  logic                     i_nrst,
  input  logic [reqcnt-1:0]        i_req_valid,
  input  logic [reqcnt-1:0]        i_req_last,
  input  logic [reqcnt*dbits-1:0]  i_req_data,
  output logic [reqcnt-1:0]        o_req_ready,
  input  logic                     i_wfull,
  output logic                     o_wr,
  output logic [dbits+$clog2(reqcnt):0] o_wdata,
  output logic                     o_busy,
  output logic [$clog2(reqcnt)-1:0] o_grant,
  output logic                     o_tmo
);
  localparam int idbits = $clog2(reqcnt);

  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;

  logic [idbits-1:0]              grant, rr_ptr, nxt_ptr, win, srch_base;
  logic [7:0]                     beats;
  logic [reqcnt-1:0][dbits-1:0]   data_v;
  logic [reqcnt-1:0]              gnt_oh, others, arb_vec;
  logic [dbits-1:0]               sel_data;
  logic busy, valid_g, accept, last_beat, cap_hit, rel, tmo_hit, win_vld;

  for (genvar i = 0; i < reqcnt; i++) begin : g_lane
    assign data_v[i] = i_req_data[i*dbits +: dbits];
    assign gnt_oh[i] = busy && (grant == idbits'(i));
  end

  assign busy      = (state == BUSY);
  assign valid_g   = |(i_req_valid & gnt_oh);
  assign accept    = valid_g & ~i_wfull;
  assign last_beat = |(i_req_last & gnt_oh);
  assign cap_hit   = ({1'b0, beats} + 9'd1) == 9'(maxburst);
  assign rel       = (accept & (last_beat | cap_hit)) | tmo_hit;
  assign nxt_ptr   = (grant == idbits'(reqcnt-1)) ? '0 : grant + 1'b1;
  assign others    = i_req_valid & ~gnt_oh;

  // One search serves both IDLE arbitration and same-cycle re-arbitration on release.
  assign arb_vec   = busy ? others : i_req_valid;
  assign srch_base = busy ? nxt_ptr : rr_ptr;

  always_comb begin
    int idx;
    idx     = 0;
    win     = '0;
    win_vld = 1'b0;
    for (int k = 0; k < reqcnt; k++) begin
      idx = int'(srch_base) + k;
      if (idx >= reqcnt) idx = idx - reqcnt;
      if (!win_vld && arb_vec[idx]) begin
        win     = idbits'(idx);
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < reqcnt; i++)
      if (gnt_oh[i]) sel_data = sel_data | data_v[i];
  end

  assign o_req_ready = gnt_oh & {reqcnt{~i_wfull}};
  assign o_wr        = accept;
  assign o_wdata     = accept ? {grant, last_beat, sel_data} : '0;
  assign o_busy      = busy;
  assign o_grant     = grant;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
      beats  <= '0;
    end else begin
      case (state)
        IDLE: if (win_vld) begin
          state <= BUSY;
          grant <= win;
          beats <= '0;
        end
        BUSY: if (rel) begin
          rr_ptr <= nxt_ptr;
          beats  <= '0;
          if (win_vld) grant <= win;
          else         state <= IDLE;
        end else if (accept) begin
          beats <= beats + 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CDC_AFIFO_ARB_TMO_EN
  logic [15:0] tmo_cnt;

  // Counts consecutive grantee-idle cycles; runs even while the FIFO is full.
  assign tmo_hit = busy & ~valid_g & (tmo_cnt == 16'(tmo-1));
  assign o_tmo   = tmo_hit;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst)                    tmo_cnt <= '0;
    else if (!busy || valid_g || rel) tmo_cnt <= '0;
    else                            tmo_cnt <= tmo_cnt + 16'd1;
  end
`else
  localparam int unused_tmo = tmo;
  assign tmo_hit = 1'b0;
  assign o_tmo   = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_afifo_wr_arb.sv
// Directed bench for cdc_afifo_wr_arb (reqcnt=4, dbits=32, maxburst=4, tmo=8).
module tb_cdc_afifo_wr_arb;
  logic         clk = 1'b0;
  logic         nrst;
  logic [3:0]   req_valid, req_last, req_ready;
  logic [127:0] req_data;
  logic         wfull, wr, busy, tmo_p;
  logic [34:0]  wdata;
  logic [1:0]   grant;

  int vec  = 0;
  int errs = 0;

  cdc_afifo_wr_arb #(.reqcnt(4), .dbits(32), .maxburst(4), .tmo(8)) dut (
    .i_clk(clk), .i_nrst(nrst), .i_req_valid(req_valid), .i_req_last(req_last),
    .i_req_data(req_data), .o_req_ready(req_ready), .i_wfull(wfull), .o_wr(wr),
    .o_wdata(wdata), .o_busy(busy), .o_grant(grant), .o_tmo(tmo_p)
  );

  always #5 clk = ~clk;

  task automatic clear_in();
    req_valid = '0; req_last = '0; req_data = '0; wfull = 1'b0;
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    clear_in();
    repeat (2) @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    nrst = 1'b0;
    #1;
    vec++;
    if ({req_ready, wr, wdata, busy, grant, tmo_p} !== '0) begin
      errs++;
      $display("FAIL reset_outputs: ready=%b wr=%b wdata=%h busy=%b grant=%0d tmo=%b, want all 0",
               req_ready, wr, wdata, busy, grant, tmo_p);
    end
    @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic test_single();
    logic [34:0] exp [3];
    exp[0] = {2'd2, 1'b0, 32'hA};
    exp[1] = {2'd2, 1'b0, 32'hB};
    exp[2] = {2'd2, 1'b1, 32'hC};
    do_reset();
    @(posedge clk); #1;
    req_valid = 4'b0100; req_data[64 +: 32] = 32'hA;
    @(negedge clk);
    vec++;
    if (req_ready !== 4'b0000 || wr !== 1'b0) begin
      errs++; $display("FAIL single_idle: ready=%b wr=%b, want 0000/0", req_ready, wr);
    end
    for (int b = 0; b < 3; b++) begin
      @(posedge clk); #1;
      req_data[64 +: 32] = 32'hA + 32'(b);
      req_last[2] = (b == 2);
      @(negedge clk);
      vec++;
      if (req_ready !== 4'b0100 || wr !== 1'b1 || wdata !== exp[b]) begin
        errs++;
        $display("FAIL single_beat%0d: ready=%b wr=%b wdata=%h, want 0100/1/%h",
                 b, req_ready, wr, wdata, exp[b]);
      end
    end
    @(posedge clk); #1;
    clear_in();
    @(negedge clk);
    vec++;
    if (busy !== 1'b0 || wr !== 1'b0) begin
      errs++; $display("FAIL single_idle_after: busy=%b wr=%b, want 0/0", busy, wr);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] eg;
    do_reset();
    @(posedge clk); #1;
    req_valid = 4'b1111; req_last = 4'b1111;
    for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = 32'h10 + 32'(i);
    @(negedge clk);
    vec++;
    if (wr !== 1'b0) begin errs++; $display("FAIL rr_first_idle: wr=%b, want 0", wr); end
    for (int c = 0; c < 5; c++) begin
      eg = 2'(c);
      @(negedge clk);
      vec++;
      if (grant !== eg || wr !== 1'b1 || wdata !== {eg, 1'b1, 32'h10 + 32'(eg)}) begin
        errs++;
        $display("FAIL rr_cycle%0d: grant=%0d wr=%b wdata=%h, want %0d/1/%h",
                 c, grant, wr, wdata, eg, {eg, 1'b1, 32'h10 + 32'(eg)});
      end
    end
  endtask

  task automatic test_maxburst();
    int n0, n1;
    logic [34:0] exp;
    n0 = 0; n1 = 0;
    do_reset();
    for (int c = 0; c < 13; c++) begin
      @(posedge clk); #1;
      req_valid = 4'b0011;
      req_data[0 +: 32]  = 32'h100 + 32'(n0);
      req_data[32 +: 32] = 32'h200 + 32'(n1);
      @(negedge clk);
      if (c >= 1) begin
        if (c <= 4)      exp = {2'd0, 1'b0, 32'h100 + 32'(c-1)};
        else if (c <= 8) exp = {2'd1, 1'b0, 32'h200 + 32'(c-5)};
        else             exp = {2'd0, 1'b0, 32'h104 + 32'(c-9)};
        vec++;
        if (wr !== 1'b1 || wdata !== exp) begin
          errs++;
          $display("FAIL maxburst_cycle%0d: wr=%b wdata=%h, want 1/%h", c, wr, wdata, exp);
        end
      end
      if (req_ready[0]) n0++;
      if (req_ready[1]) n1++;
    end
  endtask

  task automatic test_wfull();
    logic [34:0] got [$];
    int idx;
    idx = 0;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      wfull = (c >= 3 && c < 8);
      req_valid = (idx < 4) ? 4'b0010 : 4'b0000;
      req_data[32 +: 32] = 32'h30 + 32'(idx);
      req_last[1] = (idx == 3);
      @(negedge clk);
      if (wfull) begin
        vec++;
        if (wr !== 1'b0 || req_ready !== 4'b0000 || busy !== 1'b1) begin
          errs++;
          $display("FAIL wfull_hold%0d: wr=%b ready=%b busy=%b, want 0/0000/1", c, wr, req_ready, busy);
        end
      end
      if (wr) got.push_back(wdata);
      if (req_ready[1] && req_valid[1]) idx++;
    end
    vec++;
    if (got.size() != 4) begin
      errs++; $display("FAIL wfull_count: got %0d beats, want 4", got.size());
    end else begin
      for (int b = 0; b < 4; b++) begin
        vec++;
        if (got[b] !== {2'd1, (b == 3), 32'h30 + 32'(b)}) begin
          errs++;
          $display("FAIL wfull_beat%0d: got %h, want %h", b, got[b], {2'd1, (b == 3), 32'h30 + 32'(b)});
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(posedge clk); #1;
    req_valid = 4'b1000; req_data[96 +: 32] = 32'h99;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vec++;
    if (busy !== 1'b1 || wr !== 1'b1 || grant !== 2'd3) begin
      errs++; $display("FAIL rstmid_pre: busy=%b wr=%b grant=%0d, want 1/1/3", busy, wr, grant);
    end
    #1;
    req_valid = 4'b1010;
    nrst = 1'b0;
    #1;
    vec++;
    if ({req_ready, wr, wdata, busy, grant, tmo_p} !== '0) begin
      errs++;
      $display("FAIL rstmid_async: ready=%b wr=%b wdata=%h busy=%b grant=%0d, want all 0",
               req_ready, wr, wdata, busy, grant);
    end
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    vec++;
    if (busy !== 1'b1 || grant !== 2'd1 || req_ready !== 4'b0010) begin
      errs++;
      $display("FAIL rstmid_rearb: busy=%b grant=%0d ready=%b, want 1/1/0010", busy, grant, req_ready);
    end
  endtask

  task automatic test_tmo();
`ifdef CDC_AFIFO_ARB_TMO_EN
    logic       e_tmo = 1'b1;
    logic [1:0] e_g   = 2'd3;
`else
    logic       e_tmo = 1'b0;
    logic [1:0] e_g   = 2'd1;
`endif
    do_reset();
    for (int c = 0; c < 11; c++) begin
      @(posedge clk); #1;
      req_valid = (c <= 1) ? 4'b0010 : 4'b1000;
      req_data[32 +: 32] = 32'h55;
      req_data[96 +: 32] = 32'h77;
      req_last = 4'b1000;
      @(negedge clk);
      if (c == 1) begin
        vec++;
        if (grant !== 2'd1 || wr !== 1'b1) begin
          errs++; $display("FAIL tmo_grant1: grant=%0d wr=%b, want 1/1", grant, wr);
        end
      end
      if (c == 8) begin
        vec++;
        if (tmo_p !== 1'b0) begin errs++; $display("FAIL tmo_early: tmo=%b, want 0", tmo_p); end
      end
      if (c == 9) begin
        vec++;
        if (tmo_p !== e_tmo) begin errs++; $display("FAIL tmo_pulse: tmo=%b, want %b", tmo_p, e_tmo); end
      end
      if (c == 10) begin
        vec++;
        if (grant !== e_g || busy !== 1'b1 || tmo_p !== 1'b0) begin
          errs++; $display("FAIL tmo_after: grant=%0d busy=%b tmo=%b, want %0d/1/0", grant, busy, tmo_p, e_g);
        end
      end
    end
  endtask

  initial begin
    nrst = 1'b1;
    clear_in();
    test_reset();
    test_single();
    test_back_to_back();
    test_maxburst();
    test_wfull();
    test_reset_mid();
    test_tmo();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
